trackball_input_arbiter: RTL and testbench
==========================================

// Module: trackball_input_arbiter
// PURPOSE
// Shares the single trackball emulator between three input sources: PS/2 mouse, digital
// joystick and analog joystick. The last source to show activity owns the emulator until
// it has been idle for HOLD_CYCLES. Non-owner inputs are blanked so sources never fight.
// Sits between the HPS input buses and the trackball emulator; all outputs are registered.
// PARAMETERS
// HOLD_W       24          width of the ownership hold counter
// HOLD_CYCLES  12_000_000  idle clocks before ownership is released (must be < 2**HOLD_W)
// DEADZONE     10          minimum analog magnitude (0..127) that counts as activity
// PORTS
// clk                 in   1   system clock
// reset               in   1   asynchronous, active-high reset
// joystick            in   4   digital stick {up,down,left,right}, active high
// joystick_analog     in   16  {y[15:8], x[7:0]}, two's complement per axis
// ps2_mouse           in   25  [24] packet toggle, [23:16] dy, [15:8] dx, [5] sy, [4] sx
// tb_joystick         out  4   gated digital stick to the emulator
// tb_joystick_analog  out  16  gated analog stick to the emulator
// tb_joystick_mode    out  1   emulator mode select: 0 digital, 1 analog
// tb_ps2_mouse        out  25  gated mouse bus; [24] toggles only for forwarded packets
// owner               out  2   0 none, 1 mouse, 2 digital, 3 analog
// BEHAVIOUR
// - Clock and reset: single clk domain. Reset is asynchronous, active-high.
// - Reset values: all outputs 0; owner=0 (IDLE); hold counter 0. The mouse-toggle history
//   register loads ps2_mouse[24] on the first clock after reset, so no packet is seen then.
// - Activity detection, evaluated every cycle:
//   m_act = ps2_mouse[24] differs from its last-seen value AND (dx!=0 OR dy!=0)
//   d_act = |joystick
//   a_act = |x|>=DEADZONE OR |y|>=DEADZONE. |v| is computed in 8 bits, with -128 mapped to 127.
// - FSM states: IDLE, OWN_MOUSE, OWN_DIG, OWN_ANA. The owner output encodes the state.
//   IDLE: grant priority is mouse > digital > analog when several are active in the same cycle.
//     Any grant loads hold=HOLD_CYCLES. No activity: stay in IDLE.
//   OWN_x: owner activity reloads hold=HOLD_CYCLES. Otherwise hold decrements by 1.
//     When hold==0 and there is no owner activity, go to IDLE on the next cycle.
//     Non-owner activity never preempts the owner and never refreshes hold.
// - Output gating. Outputs are registered and take effect 1 clock after the input change.
//   tb_joystick = joystick in OWN_DIG, else 0.
//   tb_joystick_analog = joystick_analog in OWN_ANA, else 0.
//   tb_joystick_mode = 1 in OWN_ANA, 0 in OWN_DIG. Holds its last value in IDLE and OWN_MOUSE.
//   tb_ps2_mouse[23:0] is loaded, and tb_ps2_mouse[24] inverted, when both hold:
//     - a mouse packet edge occurs, and
//     - the state is OWN_MOUSE, or the state is IDLE and the mouse wins the grant that cycle.
//     The packet that causes the grant is forwarded in that same cycle.
//   Zero-motion packets (button only) in OWN_MOUSE are forwarded but do not refresh hold.
//   Packets arriving in any other state are dropped: no toggle, data unchanged.
// - Release to IDLE: tb_joystick and tb_joystick_analog go to 0 on the same edge that owner
//   becomes 0. tb_ps2_mouse keeps its last value.
// - Reset asserted mid-ownership: all outputs clear asynchronously. After release the block
//   starts in IDLE.
// TESTING
// 1. Reset release, no input activity, 100 clocks -> owner=0, all tb_* outputs 0, no mouse toggle.
// 2. Toggle ps2_mouse[24] with dx=5; hold joystick=4'b0001 in the same cycle -> owner=1 next clk,
//    tb_ps2_mouse[15:8]=5, tb_ps2_mouse[24] toggled, tb_joystick stays 0.
// 3. HOLD_CYCLES=16, mouse owns, stick at x=8'h40 -> owner stays 1 for exactly 17 idle clocks,
//    then 0; on the next clock owner=3, tb_joystick_mode=1, tb_joystick_analog=16'h0040.
// 4. In OWN_DIG, send 3 mouse packets with dx=7 -> tb_ps2_mouse unchanged, [24] never toggles.
// 5. Analog x=8'hF7 (-9) or x=8'h80 (|.|=127) while IDLE -> first: owner stays 0; second: owner=3.
// 6. Assert reset during OWN_ANA with joystick_analog=16'h3030 -> tb_* clear immediately, owner=0.

Source files
------------

// File: rtl/trackball_input_arbiter.sv
// trackball_input_arbiter: grants the trackball emulator to the most recently active input source
// (PS/2 mouse, digital stick, analog stick). Ownership is held until that source has been idle for HOLD_CYCLES.
module trackball_input_arbiter #(
   parameter int HOLD_W      = 24,
   parameter int HOLD_CYCLES = 12_000_000,
   parameter int DEADZONE    = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  joystick,
   input  logic [15:0] joystick_analog,
   input  logic [24:0] ps2_mouse,
   output logic [3:0]  tb_joystick,
   output logic [15:0] tb_joystick_analog,
   output logic        tb_joystick_mode,
   output logic [24:0] tb_ps2_mouse,
   output logic [1:0]  owner
);
   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] OWN_MOUSE = 2'd1;
   localparam logic [1:0] OWN_DIG   = 2'd2;
   localparam logic [1:0] OWN_ANA   = 2'd3;
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);
   logic [1:0]        state_n;
   logic [HOLD_W-1:0] hold, hold_n;
   logic [7:0]        x, y, ax, ay;
   logic              m_last, primed, m_edge, m_act, d_act, a_act, own_act, fwd;
   always_comb begin
      x = joystick_analog[7:0];
      y = joystick_analog[15:8];
      ax = x[7] ? ((x == 8'h80) ? 8'd127 : -x) : x;
      ay = y[7] ? ((y == 8'h80) ? 8'd127 : -y) : y;
      // primed masks the first clock after reset, while m_last still holds its reset value
      m_edge = primed && (ps2_mouse[24] != m_last);
      m_act = m_edge && (|ps2_mouse[23:8]);
      d_act = |joystick;
      a_act = (ax >= 8'(DEADZONE)) || (ay >= 8'(DEADZONE));
      own_act = (owner == OWN_MOUSE) ? m_act : (owner == OWN_DIG) ? d_act : a_act;
      state_n = owner;
      hold_n = hold;
      if (owner == IDLE) begin
         state_n = m_act ? OWN_MOUSE : d_act ? OWN_DIG : a_act ? OWN_ANA : IDLE;
         if (m_act || d_act || a_act) hold_n = HOLD_LOAD;
      end else if (own_act) hold_n = HOLD_LOAD;
      else if (hold == '0) state_n = IDLE;
      else hold_n = hold - 1'b1;
      fwd = m_edge && ((owner == OWN_MOUSE) || ((owner == IDLE) && m_act));
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         owner <= IDLE;
         hold <= '0;
         m_last <= 1'b0;
         primed <= 1'b0;
         tb_joystick <= '0;
         tb_joystick_analog <= '0;
         tb_joystick_mode <= 1'b0;
         tb_ps2_mouse <= '0;
      end else begin
         owner <= state_n;
         hold <= hold_n;
         m_last <= ps2_mouse[24];
         primed <= 1'b1;
         tb_joystick <= (state_n == OWN_DIG) ? joystick : '0;
         tb_joystick_analog <= (state_n == OWN_ANA) ? joystick_analog : '0;
         tb_joystick_mode <= (state_n == OWN_ANA) ? 1'b1 : (state_n == OWN_DIG) ? 1'b0 : tb_joystick_mode;
         if (fwd) tb_ps2_mouse <= {~tb_ps2_mouse[24], ps2_mouse[23:0]};
      end
   end
endmodule

// File: tb/tb_trackball_input_arbiter.sv
// tb_trackball_input_arbiter: directed bench for trackball_input_arbiter with a short hold time.
module tb_trackball_input_arbiter;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  joystick = '0;
   logic [15:0] joystick_analog = '0;
   logic [24:0] ps2_mouse = '0;
   logic [3:0]  tb_joystick;
   logic [15:0] tb_joystick_analog;
   logic        tb_joystick_mode;
   logic [24:0] tb_ps2_mouse;
   logic [1:0]  owner;
   int checks = 0;
   int errors = 0;
   int n;
   trackball_input_arbiter #(.HOLD_W(8), .HOLD_CYCLES(16), .DEADZONE(10)) dut (
      .clk(clk), .reset(reset), .joystick(joystick), .joystick_analog(joystick_analog),
      .ps2_mouse(ps2_mouse), .tb_joystick(tb_joystick), .tb_joystick_analog(tb_joystick_analog),
      .tb_joystick_mode(tb_joystick_mode), .tb_ps2_mouse(tb_ps2_mouse), .owner(owner)
   );
   always #5 clk = ~clk;
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic wait_idle(input string tag);
      n = 0;
      do begin
         step();
         n++;
      end while (owner != 2'd0 && n < 60);
      check(tag, owner, 0);
   endtask
   initial begin
      #1;
      check("reset_owner", owner, 0);
      check("reset_mouse", tb_ps2_mouse, 0);
      step();
      step();
      reset = 1'b0;
      for (int i = 0; i < 100; i++) step();
      check("idle_owner", owner, 0);
      check("idle_joy", tb_joystick, 0);
      check("idle_ana", tb_joystick_analog, 0);
      check("idle_mode", tb_joystick_mode, 0);
      check("idle_mouse", tb_ps2_mouse, 0);
      ps2_mouse = {1'b1, 8'd0, 8'd5, 8'd0};
      joystick = 4'b0001;
      step();
      check("grant_mouse_owner", owner, 1);
      check("grant_mouse_dx", tb_ps2_mouse[15:8], 5);
      check("grant_mouse_tgl", tb_ps2_mouse[24], 1);
      check("grant_mouse_joy", tb_joystick, 0);
      joystick = 4'b0000;
      joystick_analog = 16'h0040;
      n = 0;
      do begin
         step();
         n++;
         if (owner != 2'd0) check("hold_ana_blank", tb_joystick_analog, 0);
      end while (owner != 2'd0 && n < 60);
      check("hold_len", n, 17);
      check("release_owner", owner, 0);
      step();
      check("ana_owner", owner, 3);
      check("ana_mode", tb_joystick_mode, 1);
      check("ana_data", tb_joystick_analog, 16'h0040);
      joystick_analog = 16'h0000;
      wait_idle("ana_release");
      check("ana_release_data", tb_joystick_analog, 0);
      joystick = 4'b1000;
      step();
      check("dig_owner", owner, 2);
      check("dig_data", tb_joystick, 4'b1000);
      check("dig_mode", tb_joystick_mode, 0);
      for (int i = 0; i < 3; i++) begin
         ps2_mouse = {~ps2_mouse[24], 8'd0, 8'd7, 8'd0};
         step();
         check("drop_mouse", tb_ps2_mouse, 25'h1000500);
         check("drop_owner", owner, 2);
      end
      joystick = 4'b0000;
      wait_idle("dig_release");
      check("dig_release_joy", tb_joystick, 0);
      joystick_analog = 16'h00F7;
      for (int i = 0; i < 3; i++) step();
      check("dead_owner", owner, 0);
      joystick_analog = 16'h0080;
      step();
      check("min_owner", owner, 3);
      check("min_data", tb_joystick_analog, 16'h0080);
      joystick_analog = 16'h3030;
      step();
      check("ana2_data", tb_joystick_analog, 16'h3030);
      #2;
      reset = 1'b1;
      #1;
      check("async_owner", owner, 0);
      check("async_ana", tb_joystick_analog, 0);
      check("async_mode", tb_joystick_mode, 0);
      check("async_mouse", tb_ps2_mouse, 0);
      step();
      reset = 1'b0;
      step();
      check("post_reset_owner", owner, 3);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
